// File: rtl/i2s_pkg.sv
// Shared widths and the stereo sample payload for the I2S DAC transmitter.
package i2s_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned SLOT_BITS     = 32;
  localparam int unsigned SCLK_DIV_LOG2 = 4;
  localparam int unsigned UR_W          = 8;

  typedef struct packed {
    logic [DATA_W-1:0] lft;
    logic [DATA_W-1:0] rht;
  } stereo_smpl_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider and frame bit counter: SCLK, LRCLK, SCLK-fall and frame-load strobes.
module i2s_clk_gen #(
  parameter int unsigned SLOT_BITS     = i2s_pkg::SLOT_BITS,
  parameter int unsigned SCLK_DIV_LOG2 = i2s_pkg::SCLK_DIV_LOG2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             sclk,
  output logic                             lrclk,
  output logic                             sclk_fall_c,
  output logic                             load_c,
  output logic [$clog2(2*SLOT_BITS)-1:0]   bit_cnt
);

  localparam int unsigned BIT_W = $clog2(2*SLOT_BITS);

  logic [SCLK_DIV_LOG2-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '1;
    end else begin
      div_cnt <= div_cnt + SCLK_DIV_LOG2'(1);
      if (sclk_fall_c) bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Fall happens on the divider wrap; the load is the fall that wraps bit_cnt to 0.
  assign sclk_fall_c = &div_cnt;
  assign load_c      = sclk_fall_c & (&bit_cnt);
  assign sclk        = div_cnt[SCLK_DIV_LOG2-1];
  assign lrclk       = bit_cnt[BIT_W-1];

endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo I2S transmitter: sample-pair holding buffer, frame load, MSB-first serializer, underrun counter.
// Build option I2S_TX_ZERO_FILL_EN: an underrun loads silence instead of repeating the previous pair.
module i2s_dac_tx #(
  parameter int unsigned SLOT_BITS     = i2s_pkg::SLOT_BITS,
  parameter int unsigned SCLK_DIV_LOG2 = i2s_pkg::SCLK_DIV_LOG2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [i2s_pkg::DATA_W-1:0]  lft_smpl,
  input  logic [i2s_pkg::DATA_W-1:0]  rht_smpl,
  input  logic                        smpl_vld,
  output logic                        smpl_rdy,
  output logic                        SCLK,
  output logic                        LRCLK,
  output logic                        SDout,
  output logic                        frame_strt,
  output logic [i2s_pkg::UR_W-1:0]    underrun_cnt
);

  import i2s_pkg::*;

  localparam int unsigned BIT_W = $clog2(2*SLOT_BITS);
  localparam int unsigned POS_W = BIT_W - 1;
  localparam int unsigned IDX_W = $clog2(DATA_W);

  stereo_smpl_t      buf_q;
  stereo_smpl_t      act_q;
  stereo_smpl_t      act_nxt_c;
  logic              buf_full;
  logic              accept_c;
  logic              sclk_fall_c;
  logic              load_c;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  nxt_bit_c;
  logic [POS_W-1:0]  pos_c;
  logic [DATA_W-1:0] word_c;
  logic              sd_c;

  i2s_clk_gen #(
    .SLOT_BITS     (SLOT_BITS),
    .SCLK_DIV_LOG2 (SCLK_DIV_LOG2)
  ) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (SCLK),
    .lrclk       (LRCLK),
    .sclk_fall_c (sclk_fall_c),
    .load_c      (load_c),
    .bit_cnt     (bit_cnt)
  );

  assign smpl_rdy = ~buf_full;
  assign accept_c = smpl_vld & ~buf_full;

  // Data bit for the slot position the next SCLK fall moves to (one-SCLK I2S delay).
  always_comb begin
    nxt_bit_c = bit_cnt + BIT_W'(1);
    pos_c     = nxt_bit_c[POS_W-1:0];
    word_c    = nxt_bit_c[BIT_W-1] ? act_q.rht : act_q.lft;
    sd_c      = 1'b0;
    if (pos_c != '0 && 32'(pos_c) <= DATA_W) begin
      sd_c = word_c[IDX_W'(DATA_W - 32'(pos_c))];
    end
  end

  always_comb begin
    act_nxt_c = act_q;
    if (load_c) begin
      if (buf_full) act_nxt_c = buf_q;
`ifdef I2S_TX_ZERO_FILL_EN
      else          act_nxt_c = '0;
`else
      else          act_nxt_c = act_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q        <= '0;
      buf_full     <= 1'b0;
      act_q        <= '0;
      SDout        <= 1'b0;
      frame_strt   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      frame_strt <= load_c;
      act_q      <= act_nxt_c;
      if (sclk_fall_c) SDout <= sd_c;
      if (load_c && !buf_full && underrun_cnt != '1) begin
        underrun_cnt <= underrun_cnt + UR_W'(1);
      end
      // A pair accepted on an underrunning load is held for the following frame.
      if (accept_c) begin
        buf_q    <= {lft_smpl, rht_smpl};
        buf_full <= 1'b1;
      end else if (load_c) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomized self-checking bench for i2s_dac_tx against a cycle-count arithmetic model of the I2S framing.
module tb_i2s_dac_tx;
  import i2s_pkg::*;

  localparam int DW         = DATA_W;
  localparam int SB         = SLOT_BITS;
  localparam int DIVN       = 1 << SCLK_DIV_LOG2;
  localparam int FRAME      = 2 * SB;
  localparam int FRAME_CLKS = DIVN * FRAME;
  localparam int F_DIVN     = 2;
  localparam int F_FRAME    = F_DIVN * FRAME;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] lft_smpl, rht_smpl;
  logic          smpl_vld, smpl_rdy;
  logic          sclk, lrclk, sdout, frame_strt;
  logic [7:0]    underrun_cnt;

  logic          f_rst_n;
  logic [DW-1:0] f_lft = '0, f_rht = '0;
  logic          f_vld = 1'b0;
  logic          f_rdy, f_sclk, f_lrclk, f_sd, f_fs;
  logic [7:0]    f_ur;

  always #5 clk = ~clk;

  i2s_dac_tx dut (
    .clk(clk), .rst_n(rst_n), .lft_smpl(lft_smpl), .rht_smpl(rht_smpl),
    .smpl_vld(smpl_vld), .smpl_rdy(smpl_rdy), .SCLK(sclk), .LRCLK(lrclk),
    .SDout(sdout), .frame_strt(frame_strt), .underrun_cnt(underrun_cnt)
  );

  // Fast bit clock so that underrun saturation is reachable in a short run.
  i2s_dac_tx #(.SCLK_DIV_LOG2(1)) dut_fast (
    .clk(clk), .rst_n(f_rst_n), .lft_smpl(f_lft), .rht_smpl(f_rht),
    .smpl_vld(f_vld), .smpl_rdy(f_rdy), .SCLK(f_sclk), .LRCLK(f_lrclk),
    .SDout(f_sd), .frame_strt(f_fs), .underrun_cnt(f_ur)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: clocks since reset, buffer, active pair, underrun count.
  int            m_k    = 0;
  logic          m_full = 1'b0;
  logic [DW-1:0] m_buf_l = '0, m_buf_r = '0;
  logic [DW-1:0] m_act_l = '0, m_act_r = '0;
  int            m_ur   = 0;

  function automatic logic m_load(input int k);
    return (k >= DIVN) && ((k - DIVN) % FRAME_CLKS == 0);
  endfunction

  function automatic int m_bit(input int k);
    return (k / DIVN + FRAME - 1) % FRAME;
  endfunction

  function automatic logic exp_sd(input int b);
    if (b >= 1 && b <= DW)           return m_act_l[DW - b];
    if (b >= SB + 1 && b <= SB + DW) return m_act_r[SB + DW - b];
    return 1'b0;
  endfunction

  task automatic check_outputs();
    int b;
    b = m_bit(m_k);
    check("sclk",         32'(sclk),         32'((m_k % DIVN) >= DIVN / 2));
    check("lrclk",        32'(lrclk),        32'(b >= SB));
    check("sdout",        32'(sdout),        32'(exp_sd(b)));
    check("frame_strt",   32'(frame_strt),   32'(m_load(m_k)));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_ur));
  endtask

  task automatic step();
    logic          acc;
    logic [DW-1:0] dl, dr;
    check("smpl_rdy", 32'(smpl_rdy), 32'(!m_full));
    acc = smpl_vld && !m_full && rst_n;
    dl  = lft_smpl;
    dr  = rht_smpl;
    @(posedge clk);
    if (!rst_n) begin
      m_k = 0; m_full = 1'b0; m_act_l = '0; m_act_r = '0; m_ur = 0;
    end else begin
      m_k++;
      if (m_load(m_k)) begin
        if (m_full) begin
          m_act_l = m_buf_l; m_act_r = m_buf_r; m_full = 1'b0;
        end else begin
          if (m_ur < 255) m_ur++;
`ifdef I2S_TX_ZERO_FILL_EN
          m_act_l = '0; m_act_r = '0;
`endif
        end
      end
      if (acc) begin
        m_buf_l = dl; m_buf_r = dr; m_full = 1'b1;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until(input int target);
    while (m_k < target) step();
  endtask

  initial begin
    int kf, loads, exp_ur;
    rst_n = 1'b0; f_rst_n = 1'b0; smpl_vld = 1'b0; lft_smpl = '0; rht_smpl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    check("rdy_reset", 32'(smpl_rdy), 32'd1);
    rst_n = 1'b1;

    // Known pair before the first load, then a second pair offered while full.
    run_until(5);
    smpl_vld = 1'b1; lft_smpl = 16'hA5C3; rht_smpl = 16'h8001;
    step();
    check("rdy_full", 32'(smpl_rdy), 32'd0);
    lft_smpl = DW'($urandom); rht_smpl = DW'($urandom);
    run_until(DIVN);
    check("fs_first", 32'(frame_strt), 32'd1);
    check("rdy_after_load", 32'(smpl_rdy), 32'd1);
    run_until(DIVN + 1);
    smpl_vld = 1'b0;

    // Send 1234/4321, then starve.
    run_until(FRAME_CLKS + 60);
    smpl_vld = 1'b1; lft_smpl = 16'h1234; rht_smpl = 16'h4321;
    step();
    smpl_vld = 1'b0;
    run_until(3 * FRAME_CLKS + DIVN + 1);
    check("ur_starve", 32'(underrun_cnt), 32'd1);

    // Offer a pair on the very clk of an underrunning load.
    run_until(4 * FRAME_CLKS + DIVN - 1);
    smpl_vld = 1'b1; lft_smpl = DW'($urandom); rht_smpl = DW'($urandom);
    step();
    smpl_vld = 1'b0;
    check("ur_same_clk", 32'(underrun_cnt), 32'd2);
    run_until(6 * FRAME_CLKS + 100);

    // Random sparse traffic.
    while (m_k < 12 * FRAME_CLKS) begin
      smpl_vld = ($urandom_range(0, 299) == 0);
      lft_smpl = DW'($urandom);
      rht_smpl = DW'($urandom);
      step();
    end
    smpl_vld = 1'b0;

    // Mid-frame reset with a full buffer.
    while (!m_load(m_k)) step();
    smpl_vld = 1'b1; lft_smpl = DW'($urandom); rht_smpl = DW'($urandom);
    step();
    smpl_vld = 1'b0;
    while (m_bit(m_k) != 40) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_sd",  32'(sdout),        32'd0);
    check("rst_lr",  32'(lrclk),        32'd1);
    check("rst_rdy", 32'(smpl_rdy),     32'd1);
    check("rst_ur",  32'(underrun_cnt), 32'd0);
    run_until(2 * FRAME_CLKS + 100);

    // Underrun saturation on the fast instance, starved from reset.
    f_rst_n = 1'b1;
    kf = 0;
    while (kf < F_DIVN + F_FRAME * 299) begin
      @(posedge clk);
      kf++;
      @(negedge clk);
      if (kf == 2 || kf == 3 || kf == 130 || kf == F_DIVN + F_FRAME * 99 ||
          kf == F_DIVN + F_FRAME * 254 || kf == F_DIVN + F_FRAME * 299) begin
        loads  = (kf - F_DIVN) / F_FRAME + 1;
        exp_ur = (loads > 255) ? 255 : loads;
        check("fast_ur",    32'(f_ur),    32'(exp_ur));
        check("fast_fs",    32'(f_fs),    32'((kf - F_DIVN) % F_FRAME == 0));
        check("fast_sclk",  32'(f_sclk),  32'(kf % 2));
        check("fast_lrclk", 32'(f_lrclk), 32'd0);
        check("fast_sd",    32'(f_sd),    32'd0);
        check("fast_rdy",   32'(f_rdy),   32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
